switch_bcd_counter: RTL and testbench
=====================================

// Module: switch_bcd_counter
// PURPOSE
//   Downstream consumer of the per-switch debounce stages. Turns debounced Up/Down/Clear
//   switch levels into a two-digit BCD count (00..99), with hold-to-auto-repeat, and drives
//   both seven-segment digits. Sits between the Debounce_Switch outputs and the board display pins.
// PARAMETERS
//   HOLD_CYCLES    12_500_000  cycles a direction switch is held before auto-repeat starts (>=2)
//   REPEAT_CYCLES  2_500_000   cycles between auto-repeat steps (>=1)
// PORTS
//   i_Clk           in   1  system clock; the block's only clock
//   i_Reset         in   1  synchronous, active-high reset
//   i_Switch_Up     in   1  debounced level, 1 = pressed
//   i_Switch_Down   in   1  debounced level, 1 = pressed
//   i_Switch_Clear  in   1  debounced level, 1 = pressed
//   o_Tens          out  4  BCD tens digit, registered
//   o_Ones          out  4  BCD ones digit, registered
//   o_Seg_Tens      out  7  tens segments, active-low, bit6=A..bit0=G, registered
//   o_Seg_Ones      out  7  ones segments, same encoding
//   o_Wrap          out  1  one-cycle pulse on 99->00 or 00->99
// BEHAVIOUR
//   - Reset: o_Tens=o_Ones=0, o_Seg_*=7'b0000001 ("0"), o_Wrap=0, FSM=IDLE, timer=0.
//     Previous-value regs load current inputs during reset: a switch held through reset is not a press.
//   - Press = input 1 and previous-value reg 0 (rising edge); evaluated every cycle.
//   - Latency: press at cycle N -> o_Tens/o_Ones/o_Wrap updated at N+1 -> o_Seg_* at N+2.
//   - FSM (package enum): IDLE, HOLD, REPEAT; dir reg (UP/DOWN) latched on entry to HOLD.
//     IDLE: Up press with Down=0 -> step +1, dir=UP, timer=0, -> HOLD. Down press with Up=0 ->
//       step -1, dir=DOWN, -> HOLD. Up and Down both 1 when either rises -> no step, stay IDLE.
//     HOLD: dir switch low -> IDLE. timer==HOLD_CYCLES-1 -> step, timer=0, -> REPEAT; else timer++.
//     REPEAT: dir switch low -> IDLE. timer==REPEAT_CYCLES-1 -> step, timer=0; else timer++.
//     The opposite direction switch is ignored in HOLD/REPEAT.
//   - Clear: while i_Switch_Clear=1, count forced to 00, FSM=IDLE, timer=0, o_Wrap=0 every cycle;
//     dominates any simultaneous step. A direction switch already held when Clear drops
//     produces no step until released and re-pressed.
//   - Arithmetic: BCD per digit. +1: ones 9->0 carries into tens; 99->00 sets o_Wrap.
//     -1: ones 0->9 borrows from tens; 00->99 sets o_Wrap. o_Wrap high exactly one cycle.
//   - Timer width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)); never exceeds terminal value.
//   - Reset mid-HOLD/REPEAT: returns to reset state next cycle; held switch is not re-counted.
// STRUCTURE
//   - Package switch_bcd_counter_pkg: FSM state enum, dir enum, 10-entry active-low segment
//     table (0..9), SEG_BLANK constant.
//   - Sub-module seven_seg_decode (combinational BCD -> active-low segments), instantiated
//     twice; registering of o_Seg_* stays in this block. Codes 10..15 map to SEG_BLANK.
// TESTING  (bench uses HOLD_CYCLES=8, REPEAT_CYCLES=4)
//   1. Reset 3 cycles -> o_Tens=0, o_Ones=0, o_Seg_Tens=o_Seg_Ones=7'b0000001, o_Wrap=0.
//   2. Up high 3 cycles then low -> count 01 at edge+1, segs "1"(7'b1001111) at edge+2, no further step.
//   3. Up held 20 cycles from 00 -> steps at edge, +8, +12, +16, +20 -> count 05; release -> stays 05.
//   4. Count 99, Up press -> 00 with o_Wrap=1 one cycle; Down press -> 99 with o_Wrap=1 one cycle.
//   5. Count 09, Up held into REPEAT; Clear pulse -> 00 next cycle; Up still held -> stays 00
//      until Up released and re-pressed -> 01.
//   6. Up and Down rise same cycle -> no change; Up held, reset mid-REPEAT -> 00 after reset,
//      no step while Up stays high.

Source files
------------

// File: rtl/switch_bcd_counter_pkg.sv
// Shared types, segment table and BCD step helper for the switch-driven two-digit counter.
package switch_bcd_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Active-low segments, bit6 = A down to bit0 = G.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       wrap;
  } bcd_step_t;

  // One BCD step in either direction; wrap flags 99->00 and 00->99.
  function automatic bcd_step_t bcd_step(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input dir_e       dir);
    bcd_step_t r;
    r.tens = tens;
    r.ones = ones;
    r.wrap = 1'b0;
    if (dir == DIR_UP) begin
      if (ones == 4'd9) begin
        r.ones = 4'd0;
        if (tens == 4'd9) begin
          r.tens = 4'd0;
          r.wrap = 1'b1;
        end else begin
          r.tens = tens + 4'd1;
        end
      end else begin
        r.ones = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        r.ones = 4'd9;
        if (tens == 4'd0) begin
          r.tens = 4'd9;
          r.wrap = 1'b1;
        end else begin
          r.tens = tens - 4'd1;
        end
      end else begin
        r.ones = ones - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_bcd_counter_if.sv
// Signal bundle between the switch sources and the counter/display block.
interface switch_bcd_counter_if;
  import switch_bcd_counter_pkg::*;

  // No valid/ready here: switches are debounced levels sampled every cycle, and every
  // output is a registered level (o_Wrap is a single-cycle pulse) with no back-pressure.
  logic       sw_up;
  logic       sw_down;
  logic       sw_clear;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic       wrap;
  state_e     dbg_state;

  modport master (
    output sw_up, sw_down, sw_clear,
    input  tens, ones, seg_tens, seg_ones, wrap, dbg_state
  );

  modport slave (
    input  sw_up, sw_down, sw_clear,
    output tens, ones, seg_tens, seg_ones, wrap, dbg_state
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal codes blank the digit.
module seven_seg_decode
  import switch_bcd_counter_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_TABLE[i_bcd];
    end
  end

endmodule

// File: rtl/switch_bcd_counter.sv
// Two-digit BCD up/down counter driven by debounced switches, with hold-to-auto-repeat
// and registered seven-segment outputs one cycle behind the digits.
module switch_bcd_counter
  import switch_bcd_counter_pkg::*;
#(
  parameter int HOLD_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  input  logic       i_Switch_Clear,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic [6:0] o_Seg_Tens,
  output logic [6:0] o_Seg_Ones,
  output logic       o_Wrap,
  output state_e     o_Dbg_State
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        wrap_q, wrap_d;
  logic [6:0]  seg_tens_q, seg_tens_d;
  logic [6:0]  seg_ones_q, seg_ones_d;
  logic        up_prev_q, up_prev_d;
  logic        down_prev_q, down_prev_d;

  logic        up_rise;
  logic        down_rise;
  logic        dir_level;
  logic        do_step;
  dir_e        step_dir;
  bcd_step_t   step_r;

  assign up_rise   = i_Switch_Up   & ~up_prev_q;
  assign down_rise = i_Switch_Down & ~down_prev_q;
  assign dir_level = (dir_q == DIR_UP) ? i_Switch_Up : i_Switch_Down;

  // Segments decode the registered digits, giving the extra cycle of display latency.
  seven_seg_decode u_dec_tens (
    .i_bcd (tens_q),
    .o_seg (seg_tens_d)
  );

  seven_seg_decode u_dec_ones (
    .i_bcd (ones_q),
    .o_seg (seg_ones_d)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    timer_d     = timer_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    wrap_d      = 1'b0;
    up_prev_d   = i_Switch_Up;
    down_prev_d = i_Switch_Down;
    do_step     = 1'b0;
    step_dir    = dir_q;
    step_r      = '0;

    if (i_Switch_Clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A rise while the other direction is held is ambiguous and ignored.
          if (up_rise && !i_Switch_Down) begin
            do_step  = 1'b1;
            step_dir = DIR_UP;
            dir_d    = DIR_UP;
            timer_d  = '0;
            state_d  = ST_HOLD;
          end else if (down_rise && !i_Switch_Up) begin
            do_step  = 1'b1;
            step_dir = DIR_DOWN;
            dir_d    = DIR_DOWN;
            timer_d  = '0;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!dir_level) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == HOLD_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        ST_REPEAT: begin
          if (!dir_level) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == REPEAT_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase

      if (do_step) begin
        step_r = bcd_step(tens_q, ones_q, step_dir);
        tens_d = step_r.tens;
        ones_d = step_r.ones;
        wrap_d = step_r.wrap;
      end
    end
  end

  // Edge-detect history keeps tracking the pins during reset so a held switch is not a press.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      timer_q     <= '0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      wrap_q      <= 1'b0;
      seg_tens_q  <= SEG_ZERO;
      seg_ones_q  <= SEG_ZERO;
      up_prev_q   <= i_Switch_Up;
      down_prev_q <= i_Switch_Down;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      wrap_q      <= wrap_d;
      seg_tens_q  <= seg_tens_d;
      seg_ones_q  <= seg_ones_d;
      up_prev_q   <= up_prev_d;
      down_prev_q <= down_prev_d;
    end
  end

  assign o_Tens      = tens_q;
  assign o_Ones      = ones_q;
  assign o_Seg_Tens  = seg_tens_q;
  assign o_Seg_Ones  = seg_ones_q;
  assign o_Wrap      = wrap_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_switch_bcd_counter.sv
// Bench for switch_bcd_counter: vector table, hand-written hold/clear/reset sequences,
// then random switch activity against a count-level reference model.
module tb_switch_bcd_counter;
  import switch_bcd_counter_pkg::*;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  localparam logic [6:0] S_ZERO = 7'b0000001;
  localparam logic [6:0] S_ONE  = 7'b1001111;
  localparam logic [6:0] S_NINE = 7'b0000100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_bcd_counter_if bus ();

  switch_bcd_counter #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Switch_Up    (bus.sw_up),
    .i_Switch_Down  (bus.sw_down),
    .i_Switch_Clear (bus.sw_clear),
    .o_Tens         (bus.tens),
    .o_Ones         (bus.ones),
    .o_Seg_Tens     (bus.seg_tens),
    .o_Seg_Ones     (bus.seg_ones),
    .o_Wrap         (bus.wrap),
    .o_Dbg_State    (bus.dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int m_count   = 0;
  int m_held    = 0;
  int m_shown   = 0;
  bit m_active  = 0;
  bit m_dir_up  = 1;
  bit m_wrap    = 0;
  bit m_pu      = 0;
  bit m_pd      = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    logic       clr;
    int         tens;
    int         ones;
    logic       wrap;
    logic [6:0] seg_t;
    logic [6:0] seg_o;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_move(input bit up);
    if (up) begin
      m_wrap  = (m_count == 99);
      m_count = (m_count + 1) % 100;
    end else begin
      m_wrap  = (m_count == 0);
      m_count = (m_count + 99) % 100;
    end
  endtask

  // Count-level model: a press steps once, then a hold steps after HOLD cycles and every REP after.
  task automatic model_step(input logic u, input logic d, input logic c, input logic r);
    int shown;
    shown = 0;
    if (r) begin
      exp_q.delete();
      m_count  = 0;
      m_wrap   = 0;
      m_active = 0;
    end else begin
      if (exp_q.size() > 0) shown = int'(exp_q.pop_front());
      else shown = 255;
      m_wrap = 0;
      if (c) begin
        m_count  = 0;
        m_active = 0;
      end else if (m_active) begin
        if (!(m_dir_up ? u : d)) begin
          m_active = 0;
        end else begin
          m_held++;
          if (m_held >= HOLD && ((m_held - HOLD) % REP) == 0) model_move(m_dir_up);
        end
      end else if (u && !m_pu && !d) begin
        model_move(1);
        m_active = 1;
        m_dir_up = 1;
        m_held   = 0;
      end else if (d && !m_pd && !u) begin
        model_move(0);
        m_active = 1;
        m_dir_up = 0;
        m_held   = 0;
      end
    end
    m_pu = u;
    m_pd = d;
    exp_q.push_back(8'(m_count));
    m_shown = shown;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic u, input logic d, input logic c);
    rst          = r;
    bus.sw_up    = u;
    bus.sw_down  = d;
    bus.sw_clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.sw_up, bus.sw_down, bus.sw_clear, rst);
    #1;
    check("model_tens", 32'(bus.tens), 32'(m_count / 10));
    check("model_ones", 32'(bus.ones), 32'(m_count % 10));
    check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    check("model_seg_tens", 32'(bus.seg_tens), 32'(ref_seg(m_shown / 10)));
    check("model_seg_ones", 32'(bus.seg_ones), 32'(ref_seg(m_shown % 10)));
  endtask

  task automatic add_vec(input logic r, input logic u, input logic d, input logic c,
                         input int t, input int o, input logic w,
                         input logic [6:0] st, input logic [6:0] so);
    vec_t v;
    v.rst = r; v.up = u; v.dn = d; v.clr = c;
    v.tens = t; v.ones = o; v.wrap = w; v.seg_t = st; v.seg_o = so;
    vecs.push_back(v);
  endtask

  task automatic check_count(input string name, input int exp);
    check({name, "_tens"}, 32'(bus.tens), 32'(exp / 10));
    check({name, "_ones"}, 32'(bus.ones), 32'(exp % 10));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(1, 0, 0, 0);

    //        rst up dn clr  tens ones wrap seg_t   seg_o
    add_vec(1, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(1, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(1, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 1, 0, 0,  0, 1, 0, S_ZERO, S_ZERO);
    add_vec(0, 1, 0, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 1, 0, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 0, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 0, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 1, 1, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 1, 1, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 1, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 0, 0,  0, 1, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 1, 0,  0, 0, 0, S_ZERO, S_ONE);
    add_vec(0, 0, 1, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 0, 1, 0,  9, 9, 1, S_ZERO, S_ZERO);
    add_vec(0, 0, 0, 0,  9, 9, 0, S_NINE, S_NINE);
    add_vec(0, 1, 0, 0,  0, 0, 1, S_NINE, S_NINE);
    add_vec(0, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 1, 0, 1,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 1, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 0, 0, 0,  0, 0, 0, S_ZERO, S_ZERO);
    add_vec(0, 1, 0, 0,  0, 1, 0, S_ZERO, S_ZERO);
    add_vec(0, 0, 0, 0,  0, 1, 0, S_ZERO, S_ONE);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].clr);
      tick();
      check($sformatf("vec%0d_tens", i), 32'(bus.tens), 32'(vecs[i].tens));
      check($sformatf("vec%0d_ones", i), 32'(bus.ones), 32'(vecs[i].ones));
      check($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].wrap));
      check($sformatf("vec%0d_seg_tens", i), 32'(bus.seg_tens), 32'(vecs[i].seg_t));
      check($sformatf("vec%0d_seg_ones", i), 32'(bus.seg_ones), 32'(vecs[i].seg_o));
    end

    // Hold Up from 00: steps at the press, +8, +12, +16, +20.
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0); tick();
    check_count("hold_start", 0);
    drive(0, 1, 0, 0); tick();
    check_count("hold_press", 1);
    repeat (7) tick();
    check_count("hold_pre8", 1);
    tick();
    check_count("hold_8", 2);
    repeat (3) tick();
    check_count("rep_pre12", 2);
    tick();
    check_count("rep_12", 3);
    repeat (4) tick();
    check_count("rep_16", 4);
    repeat (4) tick();
    check_count("rep_20", 5);
    drive(0, 0, 0, 0);
    repeat (5) tick();
    check_count("hold_release", 5);

    // Clear while Up auto-repeats; the still-held Up must not count until re-pressed.
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
    end
    check_count("at_09", 9);
    drive(0, 1, 0, 0); tick();
    check_count("carry_10", 10);
    repeat (8) tick();
    check_count("repeat_11", 11);
    repeat (2) tick();
    drive(0, 1, 0, 1); tick();
    check_count("clear_dom", 0);
    drive(0, 1, 0, 0);
    repeat (12) tick();
    check_count("clear_held", 0);
    drive(0, 0, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    check_count("repress", 1);
    drive(0, 0, 0, 0); tick();

    // Reset mid-REPEAT with Up held through and after reset.
    drive(0, 1, 0, 0); tick();
    check_count("rst_press", 2);
    repeat (10) tick();
    check_count("rst_repeat", 3);
    drive(1, 1, 0, 0); tick();
    check_count("rst_mid", 0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    drive(0, 1, 0, 0);
    repeat (15) tick();
    check_count("rst_held", 0);
    drive(0, 0, 0, 0); tick();

    // Random switch activity against the model.
    for (int i = 0; i < 3000; i++) begin
      logic u, d, c, r;
      u = bus.sw_up;
      d = bus.sw_down;
      if ($urandom_range(0, 11) == 0) u = ~u;
      if ($urandom_range(0, 13) == 0) d = ~d;
      c = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 399) == 0);
      drive(r, u, d, c);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
